// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: port A (CPU) has fixed
// priority, port B is guaranteed a slot after MAXWAIT denials, and A can lock the bus.
module mem_arbiter #(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 8,
  parameter int unsigned MAXWAIT = 4,
  parameter int unsigned CW      = 3
) (
  input  logic          clock,
  input  logic          locked,
  input  logic          a_req,
  input  logic          a_we,
  input  logic          a_lock,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ready,
  output logic [DW-1:0] a_rdata,
  output logic          a_rvalid,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ready,
  output logic [DW-1:0] b_rdata,
  output logic          b_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

  localparam logic [CW-1:0] WAIT_MAX = CW'(MAXWAIT);

  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          lock_own_q, lock_own_d;
  logic          rd_valid_q, rd_valid_d;
  owner_e        rd_owner_q, rd_owner_d;

  logic force_b, grant_a, grant_b;

  always_comb begin
    // Grants are held low while reset is asserted so nothing reaches the memory.
    force_b = b_req && (wait_cnt_q == WAIT_MAX) && !lock_own_q;
    grant_b = locked && b_req && (!a_req || force_b) && !lock_own_q;
    grant_a = locked && a_req && !grant_b;

    a_ready = grant_a;
    b_ready = grant_b;

    if (grant_b) begin
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
      mem_we    = b_we;
    end else begin
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
      mem_we    = grant_a && a_we;
    end

    if (b_req && !grant_b) begin
      wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end else begin
      wait_cnt_d = '0;
    end

    if (!a_lock) begin
      lock_own_d = 1'b0;
    end else if (grant_a) begin
      lock_own_d = 1'b1;
    end else begin
      lock_own_d = lock_own_q;
    end

    // Per-port rvalid flops folded into one valid bit plus the port that issued the read.
    rd_valid_d = (grant_a && !a_we) || (grant_b && !b_we);
    if (grant_b) begin
      rd_owner_d = OWN_B;
    end else if (grant_a) begin
      rd_owner_d = OWN_A;
    end else begin
      rd_owner_d = rd_owner_q;
    end

    a_rdata  = mem_rdata;
    b_rdata  = mem_rdata;
    a_rvalid = rd_valid_q && (rd_owner_q == OWN_A);
    b_rvalid = rd_valid_q && (rd_owner_q == OWN_B);
  end

  always_ff @(posedge clock or negedge locked) begin
    if (!locked) begin
      wait_cnt_q <= '0;
      lock_own_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_owner_q <= OWN_A;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      lock_own_q <= lock_own_d;
      rd_valid_q <= rd_valid_d;
      rd_owner_q <= rd_owner_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural registered-read memory.
module tb_mem_arbiter;

  logic        clock;
  logic        locked;
  logic        a_req, a_we, a_lock;
  logic [15:0] a_addr;
  logic [7:0]  a_wdata;
  logic        a_ready, a_rvalid;
  logic [7:0]  a_rdata;
  logic        b_req, b_we;
  logic [15:0] b_addr;
  logic [7:0]  b_wdata;
  logic        b_ready, b_rvalid;
  logic [7:0]  b_rdata;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0] mem [0:65535];

  int n_assert = 0;
  int n_fail   = 0;
  logic exp_b;

  mem_arbiter #(.AW(16), .DW(8), .MAXWAIT(4), .CW(3)) dut (
    .clock     (clock),
    .locked    (locked),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_lock    (a_lock),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_ready   (a_ready),
    .a_rdata   (a_rdata),
    .a_rvalid  (a_rvalid),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_ready   (b_ready),
    .b_rdata   (b_rdata),
    .b_rvalid  (b_rvalid),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle();
    a_req = 1'b0; a_we = 1'b0; a_lock = 1'b0;
    b_req = 1'b0; b_we = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0100] = 8'h5A;
    mem[16'h0010] = 8'h11;
    mem[16'h0020] = 8'h22;
    mem_rdata = 8'h00;

    // Reset: requests present but all grants forced low
    locked = 1'b0;
    a_req = 1'b1; a_we = 1'b1; a_lock = 1'b0; a_addr = 16'h0100; a_wdata = 8'hFF;
    b_req = 1'b1; b_we = 1'b1; b_addr = 16'h0200; b_wdata = 8'hEE;
    #1;
    chk("rst_a_ready", a_ready, 1'b0);
    chk("rst_b_ready", b_ready, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    @(negedge clock);
    chk("rst_a_rvalid", a_rvalid, 1'b0);
    chk("rst_b_rvalid", b_rvalid, 1'b0);
    idle();
    locked = 1'b1;
    tick();

    // A read-only
    a_req = 1'b1; a_addr = 16'h0100;
    #1;
    chk("ard_a_ready", a_ready, 1'b1);
    chk("ard_b_ready", b_ready, 1'b0);
    chk("ard_mem_addr", mem_addr, 16'h0100);
    chk("ard_mem_we", mem_we, 1'b0);
    tick();
    idle();
    chk("ard_a_rvalid", a_rvalid, 1'b1);
    chk("ard_a_rdata", a_rdata, 8'h5A);
    chk("ard_b_rvalid", b_rvalid, 1'b0);
    tick();
    chk("ard_a_rvalid_drop", a_rvalid, 1'b0);

    // B write, then A reads it back
    b_req = 1'b1; b_we = 1'b1; b_addr = 16'h8000; b_wdata = 8'h33;
    #1;
    chk("bwr_b_ready", b_ready, 1'b1);
    chk("bwr_a_ready", a_ready, 1'b0);
    chk("bwr_mem_we", mem_we, 1'b1);
    chk("bwr_mem_addr", mem_addr, 16'h8000);
    chk("bwr_mem_wdata", mem_wdata, 8'h33);
    tick();
    idle();
    chk("bwr_b_rvalid", b_rvalid, 1'b0);
    a_req = 1'b1; a_addr = 16'h8000;
    #1;
    chk("bwr_rd_a_ready", a_ready, 1'b1);
    tick();
    idle();
    chk("bwr_rd_a_rvalid", a_rvalid, 1'b1);
    chk("bwr_rd_a_rdata", a_rdata, 8'h33);
    chk("bwr_mem_content", mem[16'h8000], 8'h33);
    tick();

    // Contention: A x4, B x1, repeating
    a_req = 1'b1; a_addr = 16'h0100;
    b_req = 1'b1; b_addr = 16'h0020;
    for (int i = 0; i < 10; i++) begin
      #1;
      exp_b = (i % 5 == 4);
      chk("cont_a_ready", a_ready, !exp_b);
      chk("cont_b_ready", b_ready, exp_b);
      chk("cont_mem_addr", mem_addr, exp_b ? 16'h0020 : 16'h0100);
      tick();
      chk("cont_a_rvalid", a_rvalid, !exp_b);
      chk("cont_b_rvalid", b_rvalid, exp_b);
      chk("cont_rdata", a_rdata, exp_b ? 8'h22 : 8'h5A);
    end
    idle();
    tick();

    // Interleaved reads A then B
    a_req = 1'b1; a_addr = 16'h0010;
    #1;
    chk("intl_a_ready", a_ready, 1'b1);
    tick();
    a_req = 1'b0;
    b_req = 1'b1; b_addr = 16'h0020;
    chk("intl_a_rvalid", a_rvalid, 1'b1);
    chk("intl_a_rdata", a_rdata, 8'h11);
    chk("intl_b_rvalid_lo", b_rvalid, 1'b0);
    #1;
    chk("intl_b_ready", b_ready, 1'b1);
    tick();
    idle();
    chk("intl_b_rvalid", b_rvalid, 1'b1);
    chk("intl_b_rdata", b_rdata, 8'h22);
    chk("intl_a_rvalid_lo", a_rvalid, 1'b0);
    tick();

    // Lock: B blocked while A owns the bus, even past MAXWAIT
    a_req = 1'b1; a_lock = 1'b1; a_addr = 16'h0100; b_req = 1'b1; b_addr = 16'h0020;
    #1;
    chk("lock_a_ready", a_ready, 1'b1);
    chk("lock_b_ready", b_ready, 1'b0);
    tick();
    a_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("lock_hold_b_ready", b_ready, 1'b0);
      chk("lock_hold_mem_we", mem_we, 1'b0);
      tick();
    end
    a_lock = 1'b0;
    #1;
    chk("lock_release_b_ready", b_ready, 1'b0);
    tick();
    a_req = 1'b1;
    #1;
    chk("lock_after_b_ready", b_ready, 1'b1);
    chk("lock_after_a_ready", a_ready, 1'b0);
    tick();
    idle();
    tick();

    // Reset mid-read with wait_cnt nonzero
    a_req = 1'b1; a_addr = 16'h0100; b_req = 1'b1;
    tick();
    tick();
    #1;
    chk("rmid_a_ready", a_ready, 1'b1);
    #2;
    locked = 1'b0;
    #1;
    chk("rmid_a_ready_rst", a_ready, 1'b0);
    chk("rmid_a_rvalid_rst", a_rvalid, 1'b0);
    @(negedge clock);
    chk("rmid_a_rvalid_held", a_rvalid, 1'b0);
    idle();
    locked = 1'b1;
    tick();
    chk("rmid_a_rvalid_after", a_rvalid, 1'b0);
    a_req = 1'b1; b_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      exp_b = (i == 4);
      chk("rmid_cont_a_ready", a_ready, !exp_b);
      chk("rmid_cont_b_ready", b_ready, exp_b);
      tick();
    end
    idle();
    tick();

    // Reset clears lock ownership
    a_req = 1'b1; a_lock = 1'b1;
    #1;
    chk("rlock_a_ready", a_ready, 1'b1);
    tick();
    a_req = 1'b0; b_req = 1'b1;
    #1;
    chk("rlock_b_blocked", b_ready, 1'b0);
    locked = 1'b0;
    @(negedge clock);
    locked = 1'b1;
    #1;
    chk("rlock_b_ready", b_ready, 1'b1);
    tick();
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
